// File: rtl/vga_pixel_pipe.sv
// rtl/vga_pixel_pipe.sv - VGA pixel pipeline: framebuffer fetch, test pattern, sync alignment, buffer swap
module vga_pixel_pipe #(
  parameter int H_PIXELS    = 1024,
  parameter int V_PIXELS    = 768,
  parameter int SCALE_SHIFT = 2,
  parameter int RD_LAT      = 2,
  parameter bit H_POL       = 1'b1,
  parameter bit V_POL       = 1'b1,
  localparam int FB_W = H_PIXELS >> SCALE_SHIFT,
  localparam int FB_H = V_PIXELS >> SCALE_SHIFT,
  localparam int CW   = $clog2(FB_W),
  localparam int RW   = $clog2(FB_H),
  localparam int AW   = 1 + CW + RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          h_sync_in,
  input  logic          v_sync_in,
  input  logic          disp_ena_in,
  input  logic [31:0]   row,
  input  logic [31:0]   col,
  input  logic          pattern_en,
  input  logic          swap_req,
  input  logic [11:0]   fb_data,
  output logic [AW-1:0] fb_addr,
  output logic          fb_rd_en,
  output logic [3:0]    r,
  output logic [3:0]    g,
  output logic [3:0]    b,
  output logic          h_sync,
  output logic          v_sync,
  output logic          fb_sel,
  output logic          frame_start,
  output logic          swap_ack
);

  logic [31:0]   row_s;
  logic [31:0]   col_s;
  logic          unused_hi_bits;
  logic [RD_LAT:0] hs_d;
  logic [RD_LAT:0] vs_d;
  logic [RD_LAT:0] de_d;
  logic [RD_LAT:0] pe_d;
  logic [2:0]    bar_d [0:RD_LAT];
  logic [11:0]   rgb_nxt;
  logic          vs_prev;
  logic          swap_pending;
  logic          frame_edge;

  assign row_s = row >> SCALE_SHIFT;
  assign col_s = col >> SCALE_SHIFT;
  assign unused_hi_bits = ^{row_s[31:RW], col_s[31:CW]};

  assign frame_edge = (v_sync_in == V_POL) && (vs_prev != V_POL);

  // Side-band leaves the delay line in step with fb_data arriving from memory
  always_comb begin
    rgb_nxt = 12'h000;
    if (de_d[RD_LAT]) begin
      if (pe_d[RD_LAT])
        rgb_nxt = {{4{bar_d[RD_LAT][2]}}, {4{bar_d[RD_LAT][1]}}, {4{bar_d[RD_LAT][0]}}};
      else
        rgb_nxt = fb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_rd_en     <= 1'b0;
      fb_addr      <= '0;
      hs_d         <= {(RD_LAT+1){~H_POL}};
      vs_d         <= {(RD_LAT+1){~V_POL}};
      de_d         <= '0;
      pe_d         <= '0;
      for (int i = 0; i <= RD_LAT; i++) bar_d[i] <= 3'd0;
      {r, g, b}    <= 12'h000;
      h_sync       <= ~H_POL;
      v_sync       <= ~V_POL;
      vs_prev      <= ~V_POL;
      fb_sel       <= 1'b0;
      frame_start  <= 1'b0;
      swap_ack     <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      fb_rd_en <= disp_ena_in & ~pattern_en;
      if (disp_ena_in & ~pattern_en)
        fb_addr <= {fb_sel, row_s[RW-1:0], col_s[CW-1:0]};

      hs_d <= {hs_d[RD_LAT-1:0], h_sync_in};
      vs_d <= {vs_d[RD_LAT-1:0], v_sync_in};
      de_d <= {de_d[RD_LAT-1:0], disp_ena_in};
      pe_d <= {pe_d[RD_LAT-1:0], pattern_en};
      bar_d[0] <= col[9:7];
      for (int i = 1; i <= RD_LAT; i++) bar_d[i] <= bar_d[i-1];

      {r, g, b} <= rgb_nxt;
      h_sync    <= hs_d[RD_LAT];
      v_sync    <= vs_d[RD_LAT];

      // Buffer swaps only land on a frame edge so one frame never mixes buffers
      vs_prev     <= v_sync_in;
      frame_start <= frame_edge;
      if (frame_edge && (swap_pending || swap_req)) begin
        fb_sel       <= ~fb_sel;
        swap_ack     <= 1'b1;
        swap_pending <= 1'b0;
      end else begin
        swap_ack <= 1'b0;
        if (swap_req) swap_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// tb/tb_vga_pixel_pipe.sv - directed self-checking bench for vga_pixel_pipe
module tb_vga_pixel_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        h_sync_in, v_sync_in, disp_ena_in;
  logic [31:0] row, col;
  logic        pattern_en, swap_req;
  logic [11:0] fb_data;
  logic [16:0] fb_addr;
  logic        fb_rd_en;
  logic [3:0]  r, g, b;
  logic        h_sync, v_sync, fb_sel, frame_start, swap_ack;
  logic [11:0] md0, md1;
  int          checks = 0;
  int          errors = 0;
  int          hs_width;

  always #5 clk = ~clk;

  vga_pixel_pipe dut (
    .clk(clk), .rst(rst),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .disp_ena_in(disp_ena_in),
    .row(row), .col(col), .pattern_en(pattern_en), .swap_req(swap_req),
    .fb_data(fb_data), .fb_addr(fb_addr), .fb_rd_en(fb_rd_en),
    .r(r), .g(g), .b(b), .h_sync(h_sync), .v_sync(v_sync),
    .fb_sel(fb_sel), .frame_start(frame_start), .swap_ack(swap_ack)
  );

  function automatic logic [11:0] mem_rd(input logic [16:0] a);
    if (a == 17'h00102) return 12'hA5C;
    return a[11:0] ^ 12'h5A5;
  endfunction

  // Two-deep registered memory: data valid RD_LAT=2 cycles after the address edge
  always @(posedge clk) begin
    md0 <= mem_rd(fb_addr);
    md1 <= md0;
  end
  assign fb_data = md1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [11:0] bar_rgb(input int c);
    logic [2:0] k;
    k = 3'((c >> 7) & 7);
    return {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
  endfunction

  initial begin
    rst = 1'b1; h_sync_in = 1'b0; v_sync_in = 1'b0; disp_ena_in = 1'b0;
    row = 0; col = 0; pattern_en = 1'b0; swap_req = 1'b0;
    @(negedge clk);
    step(); step();
    chk("rst_rd_en", fb_rd_en, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_rgb", {r, g, b}, 0);
    chk("rst_hs", h_sync, 0);
    chk("rst_vs", v_sync, 0);
    chk("rst_sel", fb_sel, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_ack", swap_ack, 0);

    // Single framebuffer pixel, latency 3
    rst = 1'b0; step();
    row = 5; col = 9; disp_ena_in = 1'b1;
    step();
    chk("px_addr", fb_addr, 32'h00102);
    chk("px_rd_en", fb_rd_en, 1);
    disp_ena_in = 1'b0;
    step();
    chk("px_addr_hold", fb_addr, 32'h00102);
    chk("px_rd_en_off", fb_rd_en, 0);
    step();
    chk("px_early", {r, g, b}, 0);
    step();
    chk("px_rgb", {r, g, b}, 32'hA5C);
    step();
    chk("px_after", {r, g, b}, 0);

    // Framebuffer line of 8 pixels
    row = 100;
    for (int i = 0; i < 11; i++) begin
      disp_ena_in = (i < 8);
      col = i * 4;
      step();
      if (i >= 3) chk("fb_line", {r, g, b}, 32'((12'h900 | 12'(i - 3)) ^ 12'h5A5));
      else        chk("fb_line_pre", {r, g, b}, 0);
    end

    // 96-cycle h_sync pulse in blanking
    hs_width = 0;
    for (int i = 0; i < 106; i++) begin
      h_sync_in = (i >= 2 && i < 98);
      step();
      chk("hs_delay", h_sync, 32'((i - 3 >= 2) && (i - 3 < 98)));
      chk("hs_blank_rgb", {r, g, b}, 0);
      if (h_sync) hs_width++;
    end
    chk("hs_width", hs_width, 96);

    // Colour bars across an active line
    row = 0; pattern_en = 1'b1;
    for (int i = 0; i < 1027; i++) begin
      disp_ena_in = (i < 1024);
      col = i;
      step();
      chk("pat_rd_en", fb_rd_en, 0);
      if (i >= 3 && i - 3 < 1024) chk("pat_bar", {r, g, b}, 32'(bar_rgb(i - 3)));
      else                         chk("pat_blank", {r, g, b}, 0);
    end
    chk("pat_addr_hold", fb_addr, 32'h01907);
    pattern_en = 1'b0; disp_ena_in = 1'b0;

    // Three swap requests then one frame edge
    for (int i = 0; i < 3; i++) begin
      swap_req = 1'b1; step();
      swap_req = 1'b0; step();
      chk("swp_no_ack", swap_ack, 0);
      chk("swp_sel_hold", fb_sel, 0);
    end
    v_sync_in = 1'b1; step();
    chk("swp_sel", fb_sel, 1);
    chk("swp_ack", swap_ack, 1);
    chk("swp_fs", frame_start, 1);
    step();
    chk("swp_ack_once", swap_ack, 0);
    chk("swp_fs_once", frame_start, 0);
    disp_ena_in = 1'b1; row = 0; col = 0; step();
    chk("swp_addr_msb", fb_addr, 32'h10000);
    disp_ena_in = 1'b0;
    v_sync_in = 1'b0; step(); step();
    v_sync_in = 1'b1; step();
    chk("swp_next_fs", frame_start, 1);
    chk("swp_next_ack", swap_ack, 0);
    chk("swp_next_sel", fb_sel, 1);

    // Reset mid-line with white bars flowing
    v_sync_in = 1'b0; pattern_en = 1'b1; disp_ena_in = 1'b1; col = 1023; h_sync_in = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("mid_white", {r, g, b}, 32'hFFF);
    rst = 1'b1; step();
    chk("mrst_rgb", {r, g, b}, 0);
    chk("mrst_hs", h_sync, 0);
    chk("mrst_rd_en", fb_rd_en, 0);
    chk("mrst_addr", fb_addr, 0);
    chk("mrst_sel", fb_sel, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mrst_recover", {r, g, b}, (i >= 3) ? 32'hFFF : 32'h0);
    end
    pattern_en = 1'b0; disp_ena_in = 1'b0; h_sync_in = 1'b0;

    // swap_req coincident with the frame edge
    step(); step();
    v_sync_in = 1'b1; swap_req = 1'b1; step();
    chk("co_sel", fb_sel, 1);
    chk("co_ack", swap_ack, 1);
    swap_req = 1'b0; v_sync_in = 1'b0; step(); step();
    v_sync_in = 1'b1; step();
    chk("co_next_fs", frame_start, 1);
    chk("co_next_ack", swap_ack, 0);
    chk("co_next_sel", fb_sel, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pixel_pipe.md
VGA_PIXEL_PIPE -- requirements
Module: vga_pixel_pipe

Interface
REQ-001 Parameter H_PIXELS, default 1024, active pixels per line.
REQ-002 Parameter V_PIXELS, default 768, active lines per frame.
REQ-003 Parameter SCALE_SHIFT, default 2, log2 of the pixel replication factor per axis.
REQ-004 Parameter RD_LAT, default 2 (range 1..4), framebuffer read latency in clk cycles.
REQ-005 Parameters H_POL, default 1, and V_POL, default 1, sync active levels, shared with the timing generator.
REQ-006 Derived FB_W = H_PIXELS>>SCALE_SHIFT (256), FB_H = V_PIXELS>>SCALE_SHIFT (192), AW = 1+clog2(FB_W)+clog2(FB_H) (17).
REQ-007 clk  in  1  pixel clock.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 h_sync_in, v_sync_in, disp_ena_in  in  1 each  timing-generator outputs.
REQ-010 row, col  in  32 each  timing-generator cursor.
REQ-011 pattern_en  in  1  selects the colour-bar test pattern instead of framebuffer data.
REQ-012 swap_req  in  1  single-cycle request to toggle the displayed buffer.
REQ-013 fb_data  in  12  {R[3:0],G[3:0],B[3:0]}, valid RD_LAT cycles after the fb_rd_en edge.
REQ-014 fb_addr  out  AW  {fb_sel, row>>SCALE_SHIFT, col>>SCALE_SHIFT}.
REQ-015 fb_rd_en  out  1  read strobe.
REQ-016 r, g, b  out  4 each  pixel colour.
REQ-017 h_sync, v_sync  out  1 each  syncs aligned with r/g/b.
REQ-018 fb_sel  out  1  currently displayed buffer.
REQ-019 frame_start  out  1  one-cycle pulse at the v_sync_in inactive->active edge.
REQ-020 swap_ack  out  1  one-cycle pulse when a swap takes effect.

Function
REQ-021 Stage A: at each edge, fb_rd_en <= disp_ena_in & ~pattern_en; fb_addr <= {fb_sel, row[..]>>SCALE_SHIFT, col[..]>>SCALE_SHIFT}, truncated to field widths; fb_addr holds its last value when fb_rd_en is 0.
REQ-022 Side-band h_sync_in, v_sync_in, disp_ena_in, pattern_en, and col[9:7] shall pass through a shift register of depth RD_LAT+1.
REQ-023 Output stage: r/g/b are registered at the edge where fb_data is valid; total latency from input sample to r/g/b/h_sync/v_sync is RD_LAT+1 cycles, identical for all of them.
REQ-024 When delayed disp_ena is 0, r/g/b = 0.
REQ-025 When delayed disp_ena is 1 and delayed pattern_en is 1, colour = bar(col[9:7]): bit2 -> R=F, bit1 -> G=F, bit0 -> B=F; otherwise 0 (bar 0 black, bar 7 white).
REQ-026 Otherwise, r/g/b = fb_data[11:8], fb_data[7:4], fb_data[3:0].
REQ-027 Edge detect on v_sync_in against its registered previous value; frame_start is asserted the cycle after the edge sample, unaligned with the delayed outputs.
REQ-028 swap_req sets a swap_pending flag; on the frame_start edge, if swap_pending or swap_req is 1, fb_sel toggles, swap_ack pulses, and swap_pending clears.
REQ-029 Multiple swap_req pulses before one frame edge produce exactly one toggle.
REQ-030 A swap_req in the same cycle as the frame edge is applied at that edge and does not leave pending set.
REQ-031 fb_sel changes only at a frame edge, so all reads of one frame use a single buffer.

Reset
REQ-032 While rst=1: fb_rd_en=0, fb_addr=0, r=g=b=0, h_sync=~H_POL, v_sync=~V_POL, fb_sel=0, frame_start=0, swap_ack=0, swap_pending=0.
REQ-033 While rst=1, all delay-line entries are cleared to inactive sync and disp_ena=0, and the v_sync edge register is loaded with ~V_POL.
REQ-034 A reset asserted mid-frame shall discard in-flight pixels; the first non-blank output occurs RD_LAT+1 cycles after the first disp_ena_in=1 following reset release.

Verification
REQ-035 Drive row=5, col=9, disp_ena_in=1, fb_sel=0 -> next cycle fb_addr=0x00102, fb_rd_en=1; fb_data=0xA5C returned at RD_LAT -> r=A, g=5, b=C exactly 3 cycles after the input (RD_LAT=2).
REQ-036 Drive h_sync_in pulse of 96 cycles -> h_sync mirrors it delayed by 3 cycles with identical width; r/g/b stay 0 throughout blanking.
REQ-037 Drive pattern_en=1, col=0..1023 on an active line -> 8 bars of 128 px in order 000,00F,0F0,0FF,F00,F0F,FF0,FFF; fb_rd_en stays 0.
REQ-038 Apply 3 swap_req pulses mid-frame, then a v_sync edge -> a single swap_ack, fb_sel 0->1, fb_addr[16]=1 on the next frame.
REQ-039 Assert swap_req in the same cycle as the v_sync edge -> fb_sel toggles once, with no further toggle at the next frame.
REQ-040 Assert rst mid-line with disp_ena_in=1 -> the next cycle has all outputs at reset values, and outputs return to valid RD_LAT+1 cycles after the first active pixel.
